// File: rtl/load_bias_pp.sv
// Ping-pong bias loader: fetches a bias vector from DDR over an AXI4 read channel
// in 4 KB-safe bursts into one of two RAM banks while the other bank stays readable.
module load_bias_pp #(
  parameter int unsigned C_M_AXI_LEN_WIDTH  = 8,
  parameter int unsigned C_M_AXI_ADDR_WIDTH = 32,
  parameter int unsigned C_M_AXI_DATA_WIDTH = 128,
  parameter int unsigned C_RAM_ADDR_WIDTH   = 10,
  parameter int unsigned C_BURST_MAX        = 16
) (
  input  logic                          I_clk,
  input  logic                          I_rst_n,
  input  logic                          I_ap_start,
  output logic                          O_ap_done,
  output logic                          O_busy,
  output logic                          O_err,
  input  logic [C_M_AXI_ADDR_WIDTH-1:0] I_base_addr,
  input  logic [C_RAM_ADDR_WIDTH:0]     I_len,
  input  logic                          I_wbank,
  input  logic                          I_rbank,
  input  logic [C_RAM_ADDR_WIDTH-1:0]   I_braddr,
  output logic [C_M_AXI_DATA_WIDTH-1:0] O_brdata,
  output logic [C_M_AXI_ADDR_WIDTH-1:0] O_maxi_araddr,
  output logic [C_M_AXI_LEN_WIDTH-1:0]  O_maxi_arlen,
  output logic                          O_maxi_arvalid,
  input  logic                          I_maxi_arready,
  output logic                          O_maxi_rready,
  input  logic                          I_maxi_rvalid,
  input  logic [C_M_AXI_DATA_WIDTH-1:0] I_maxi_rdata,
  input  logic                          I_maxi_rlast
);

  localparam int unsigned AW    = C_M_AXI_ADDR_WIDTH;
  localparam int unsigned DW    = C_M_AXI_DATA_WIDTH;
  localparam int unsigned LW    = C_M_AXI_LEN_WIDTH;
  localparam int unsigned RW    = C_RAM_ADDR_WIDTH;
  localparam int unsigned BPB   = DW / 8;
  localparam int unsigned BSH   = $clog2(BPB);
  localparam int unsigned DEPTH = 1 << RW;
  localparam int unsigned CW0   = (RW > LW) ? RW + 1 : LW + 1;
  localparam int unsigned CW    = (CW0 > 13) ? CW0 : 13;

  typedef enum logic [1:0] {S_IDLE, S_AR, S_R, S_DONE} state_t;

  state_t        state, state_nxt;
  logic          start_q, start;
  logic [AW-1:0] addr_q, addr_d;
  logic [RW:0]   len_q, len_d, offset_q, offset_d, rem_q, rem_d;
  logic          wbank_q, wbank_d;
  logic [LW-1:0] beat_q, beat_d, last_q, last_d;
  logic          err_d, we_d, we_q;
  logic [RW:0]   wa_q, ra_q;
  logic [DW-1:0] wd_q;
  logic          beat_ok, final_beat;
  logic [12:0]   bnd_bytes;
  logic [CW-1:0] bnd_beats, rem_w, burst_a, burst;

  logic [DW-1:0] mem [0:2*DEPTH-1];

  assign start      = I_ap_start && !start_q && (state == S_IDLE);
  assign rem_q      = len_q - offset_q;
  assign beat_ok    = (state == S_R) && I_maxi_rvalid;
  assign final_beat = (beat_q == last_q);

  // Burst length for the next AR: min(remaining, C_BURST_MAX, beats to 4 KB boundary)
  assign rem_d     = len_d - offset_d;
  assign bnd_bytes = 13'd4096 - {1'b0, addr_d[11:0]};
  assign bnd_beats = CW'(bnd_bytes >> BSH);
  assign rem_w     = CW'(rem_d);
  assign burst_a   = (rem_w < CW'(C_BURST_MAX)) ? rem_w : CW'(C_BURST_MAX);
  assign burst     = (burst_a < bnd_beats) ? burst_a : bnd_beats;

  // State register
  always_ff @(posedge I_clk or negedge I_rst_n) begin
    if (!I_rst_n) state <= S_IDLE;
    else          state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: if (start) state_nxt = (I_len == '0) ? S_DONE : S_AR;
      S_AR:   if (I_maxi_arready) state_nxt = S_R;
      S_R:    if (beat_ok && final_beat)
                state_nxt = (rem_q == (RW+1)'(1)) ? S_DONE : S_AR;
      S_DONE: state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Datapath next values; end of burst is decided by the beat count, rlast is only checked
  always_comb begin
    addr_d   = addr_q;
    len_d    = len_q;
    offset_d = offset_q;
    wbank_d  = wbank_q;
    beat_d   = beat_q;
    last_d   = last_q;
    err_d    = O_err;
    we_d     = 1'b0;
    case (state)
      S_IDLE: if (start) begin
        addr_d   = I_base_addr;
        len_d    = I_len;
        offset_d = '0;
        wbank_d  = I_wbank;
        err_d    = 1'b0;
      end
      S_AR: if (I_maxi_arready) begin
        beat_d = '0;
        last_d = O_maxi_arlen;
      end
      S_R: if (beat_ok) begin
        we_d     = 1'b1;
        addr_d   = addr_q + AW'(BPB);
        offset_d = offset_q + (RW+1)'(1);
        beat_d   = beat_q + LW'(1);
        if (final_beat != I_maxi_rlast) err_d = 1'b1;
      end
      default: ;
    endcase
  end

  // Registered datapath, write pipeline and outputs
  always_ff @(posedge I_clk or negedge I_rst_n) begin
    if (!I_rst_n) begin
      start_q        <= 1'b0;
      addr_q         <= '0;
      len_q          <= '0;
      offset_q       <= '0;
      wbank_q        <= 1'b0;
      beat_q         <= '0;
      last_q         <= '0;
      O_err          <= 1'b0;
      we_q           <= 1'b0;
      wa_q           <= '0;
      wd_q           <= '0;
      ra_q           <= '0;
      O_maxi_arvalid <= 1'b0;
      O_maxi_rready  <= 1'b0;
      O_ap_done      <= 1'b0;
      O_busy         <= 1'b0;
      O_maxi_araddr  <= '0;
      O_maxi_arlen   <= '0;
    end else begin
      start_q        <= I_ap_start;
      addr_q         <= addr_d;
      len_q          <= len_d;
      offset_q       <= offset_d;
      wbank_q        <= wbank_d;
      beat_q         <= beat_d;
      last_q         <= last_d;
      O_err          <= err_d;
      we_q           <= we_d;
      wa_q           <= {wbank_q, offset_q[RW-1:0]};
      wd_q           <= I_maxi_rdata;
      ra_q           <= {I_rbank, I_braddr};
      O_maxi_arvalid <= (state_nxt == S_AR);
      O_maxi_rready  <= (state_nxt == S_R);
      O_ap_done      <= (state_nxt == S_DONE);
      O_busy         <= (state_nxt != S_IDLE);
      O_maxi_araddr  <= addr_d;
      O_maxi_arlen   <= LW'(burst - CW'(1));
    end
  end

  // Two banks in one array; contents are never reset
  always_ff @(posedge I_clk) begin
    if (we_q) mem[wa_q] <= wd_q;
    O_brdata <= mem[ra_q];
  end

endmodule

// File: tb/tb_load_bias_pp.sv
// Self-checking bench for load_bias_pp: AXI read slave model plus expected-AR and
// expected-word scoreboards, one task per scenario.
module tb_load_bias_pp;

  localparam int unsigned AW = 32;
  localparam int unsigned DW = 128;
  localparam int unsigned RW = 10;
  localparam int unsigned LW = 8;

  logic          clk;
  logic          rst_n;
  logic          ap_start, ap_done, busy, err;
  logic [AW-1:0] base_addr;
  logic [RW:0]   len;
  logic          wbank, rbank;
  logic [RW-1:0] braddr;
  logic [DW-1:0] brdata;
  logic [AW-1:0] araddr;
  logic [LW-1:0] arlen;
  logic          arvalid, arready, rready, rvalid, rlast;
  logic [DW-1:0] rdata;

  load_bias_pp dut (
    .I_clk(clk), .I_rst_n(rst_n), .I_ap_start(ap_start), .O_ap_done(ap_done),
    .O_busy(busy), .O_err(err), .I_base_addr(base_addr), .I_len(len),
    .I_wbank(wbank), .I_rbank(rbank), .I_braddr(braddr), .O_brdata(brdata),
    .O_maxi_araddr(araddr), .O_maxi_arlen(arlen), .O_maxi_arvalid(arvalid),
    .I_maxi_arready(arready), .O_maxi_rready(rready), .I_maxi_rvalid(rvalid),
    .I_maxi_rdata(rdata), .I_maxi_rlast(rlast)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {logic [AW-1:0] addr; logic [LW-1:0] len;} ar_t;
  typedef struct {logic bank; logic [RW-1:0] addr; logic [DW-1:0] data;} wexp_t;

  ar_t   exp_ar_q[$];
  ar_t   obs_ar_q[$];
  wexp_t exp_w_q[$];
  int    checks, failures;
  int    cfg_ardly, cfg_gap, cfg_early;
  int    beat_total, ar_unstable, done_cnt;

  // DDR content model
  function automatic logic [DW-1:0] word_of(input logic [AW-1:0] a);
    return {a, a ^ 32'hA5A5_5A5A, ~a, a + 32'h1234_5678};
  endfunction

  function automatic int burst_of(input logic [AW-1:0] a, input int rem);
    int b, bnd;
    b = (rem > 16) ? 16 : rem;
    bnd = (4096 - int'(a[11:0])) / 16;
    return (b > bnd) ? bnd : b;
  endfunction

  task automatic push_bursts(input logic [AW-1:0] base, input int n);
    logic [AW-1:0] a;
    int rem, b;
    ar_t e;
    a = base;
    rem = n;
    while (rem > 0) begin
      b = burst_of(a, rem);
      e.addr = a;
      e.len  = LW'(b - 1);
      exp_ar_q.push_back(e);
      a = a + AW'(16 * b);
      rem = rem - b;
    end
  endtask

  task automatic push_words(input logic [AW-1:0] base, input int n, input logic bank);
    wexp_t w;
    for (int i = 0; i < n; i++) begin
      w.bank = bank;
      w.addr = RW'(i);
      w.data = word_of(base + AW'(16 * i));
      exp_w_q.push_back(w);
    end
  endtask

  task automatic start_load(input logic [AW-1:0] base, input int n, input logic bank);
    @(negedge clk);
    base_addr = base;
    len = (RW+1)'(n);
    wbank = bank;
    ap_start = 1'b1;
    @(negedge clk);
    ap_start = 1'b0;
  endtask

  task automatic wait_done(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (ap_done === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic read_word(input logic bank, input logic [RW-1:0] a, output logic [DW-1:0] d);
    @(negedge clk);
    rbank = bank;
    braddr = a;
    @(posedge clk);
    @(posedge clk);
    #1 d = brdata;
  endtask

  // Done-pulse monitor
  always @(negedge clk) if (ap_done === 1'b1) done_cnt++;

  // AXI read slave: records ARs, serves beats with configurable delays and rlast fault
  logic          ar_hs, r_hs, arvalid_s, rready_s, ar_held;
  logic [AW-1:0] araddr_s, sl_addr;
  logic [LW-1:0] arlen_s;
  int            ar_wait, sl_left, sl_idx;
  initial begin
    arready = 1'b0; rvalid = 1'b0; rdata = '0; rlast = 1'b0;
    arvalid_s = 1'b0; rready_s = 1'b0; ar_held = 1'b0;
    araddr_s = '0; arlen_s = '0; sl_addr = '0; ar_wait = 0; sl_left = 0; sl_idx = 0;
    forever begin
      @(posedge clk);
      ar_hs = arready && arvalid_s && rst_n;
      r_hs  = rvalid && rready_s && rst_n;
      #1;
      if (!rst_n) begin
        arready = 1'b0; rvalid = 1'b0; rlast = 1'b0;
        arvalid_s = 1'b0; rready_s = 1'b0; ar_held = 1'b0; ar_wait = 0; sl_left = 0;
      end else begin
        if (ar_hs) begin
          obs_ar_q.push_back({araddr_s, arlen_s});
          sl_addr = araddr_s; sl_left = int'(arlen_s) + 1; sl_idx = 0;
          ar_wait = 0; ar_held = 1'b0;
        end
        if (r_hs) begin
          beat_total++; sl_addr = sl_addr + 32'd16; sl_left--; sl_idx++;
        end
        arvalid_s = arvalid;
        rready_s  = rready;
        if (arvalid_s) begin
          if (ar_held && (araddr !== araddr_s || arlen !== arlen_s)) ar_unstable++;
          araddr_s = araddr; arlen_s = arlen; ar_held = 1'b1;
          arready = (ar_wait >= cfg_ardly);
          if (!arready) ar_wait++;
        end else begin
          arready = 1'b0; ar_held = 1'b0;
        end
        if (rvalid && !r_hs) begin
          // hold the pending beat
        end else if (sl_left > 0 && int'($urandom_range(99)) >= cfg_gap) begin
          rvalid = 1'b1;
          rdata  = word_of(sl_addr);
          rlast  = (sl_left == 1) || (sl_idx + 1 == cfg_early);
        end else begin
          rvalid = 1'b0; rlast = 1'b0;
        end
      end
    end
  end

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({arvalid, rready, busy, ap_done, err} !== 5'b0) begin
      failures++;
      $display("FAIL reset_in got=%b exp=00000", {arvalid, rready, busy, ap_done, err});
    end
    @(negedge clk) rst_n = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if ({arvalid, rready, busy, ap_done, err} !== 5'b0) begin
      failures++;
      $display("FAIL reset_out got=%b exp=00000", {arvalid, rready, busy, ap_done, err});
    end
  endtask

  task automatic test_single_burst();
    int d0, b0;
    bit ok;
    ar_t e, o;
    wexp_t w;
    logic [DW-1:0] rd;
    cfg_ardly = 0; cfg_gap = 0; cfg_early = 0;
    d0 = done_cnt; b0 = beat_total;
    e.addr = 32'h1000; e.len = 8'd7;
    exp_ar_q.push_back(e);
    push_words(32'h1000, 8, 1'b0);
    start_load(32'h1000, 8, 1'b0);
    wait_done(500, ok);
    repeat (4) @(negedge clk);
    checks++;
    if (!ok) begin failures++; $display("FAIL single_done timeout"); end
    checks++;
    if (done_cnt - d0 != 1) begin failures++; $display("FAIL single_pulses got=%0d exp=1", done_cnt - d0); end
    checks++;
    if (err !== 1'b0) begin failures++; $display("FAIL single_err got=%b exp=0", err); end
    checks++;
    if (beat_total - b0 != 8) begin failures++; $display("FAIL single_beats got=%0d exp=8", beat_total - b0); end
    while (exp_ar_q.size() > 0) begin
      e = exp_ar_q.pop_front();
      checks++;
      if (obs_ar_q.size() == 0) begin
        failures++; $display("FAIL single_ar missing exp addr=%h len=%0d", e.addr, e.len);
      end else begin
        o = obs_ar_q.pop_front();
        if (o !== e) begin
          failures++; $display("FAIL single_ar got addr=%h len=%0d exp addr=%h len=%0d", o.addr, o.len, e.addr, e.len);
        end
      end
    end
    checks++;
    if (obs_ar_q.size() != 0) begin failures++; $display("FAIL single_ar_extra got=%0d exp=0", obs_ar_q.size()); obs_ar_q.delete(); end
    while (exp_w_q.size() > 0) begin
      w = exp_w_q.pop_front();
      read_word(w.bank, w.addr, rd);
      checks++;
      if (rd !== w.data) begin failures++; $display("FAIL single_rd addr=%0d got=%h exp=%h", w.addr, rd, w.data); end
    end
  endtask

  task automatic test_pingpong();
    bit ok;
    wexp_t w;
    logic [DW-1:0] rd;
    cfg_ardly = 1; cfg_gap = 30; cfg_early = 0;
    push_bursts(32'h3000, 24);
    push_words(32'h3000, 24, 1'b1);
    fork
      begin
        start_load(32'h3000, 24, 1'b1);
        wait_done(1000, ok);
      end
      begin
        logic [DW-1:0] r0;
        for (int i = 0; i < 30; i++) begin
          read_word(1'b0, RW'(i % 8), r0);
          checks++;
          if (r0 !== word_of(32'h1000 + 32'(16 * (i % 8)))) begin
            failures++; $display("FAIL pp_bank0 addr=%0d got=%h exp=%h", i % 8, r0, word_of(32'h1000 + 32'(16 * (i % 8))));
          end
        end
      end
    join
    checks++;
    if (!ok) begin failures++; $display("FAIL pp_done timeout"); end
    checks++;
    if (obs_ar_q.size() != exp_ar_q.size()) begin
      failures++; $display("FAIL pp_ar_count got=%0d exp=%0d", obs_ar_q.size(), exp_ar_q.size());
    end
    exp_ar_q.delete(); obs_ar_q.delete();
    while (exp_w_q.size() > 0) begin
      w = exp_w_q.pop_front();
      read_word(w.bank, w.addr, rd);
      checks++;
      if (rd !== w.data) begin failures++; $display("FAIL pp_bank1 addr=%0d got=%h exp=%h", w.addr, rd, w.data); end
    end
  endtask

  task automatic test_split();
    bit ok;
    ar_t e, o;
    wexp_t w;
    logic [DW-1:0] rd;
    logic [AW-1:0] adr [4];
    int bl [4];
    adr[0] = 32'h0FC0; adr[1] = 32'h1000; adr[2] = 32'h1100; adr[3] = 32'h1200;
    bl[0] = 4; bl[1] = 16; bl[2] = 16; bl[3] = 4;
    cfg_ardly = 0; cfg_gap = 0; cfg_early = 0;
    for (int i = 0; i < 4; i++) begin
      e.addr = adr[i]; e.len = LW'(bl[i] - 1);
      exp_ar_q.push_back(e);
    end
    push_words(32'h0FC0, 40, 1'b0);
    start_load(32'h0FC0, 40, 1'b0);
    wait_done(1000, ok);
    checks++;
    if (!ok) begin failures++; $display("FAIL split_done timeout"); end
    while (exp_ar_q.size() > 0) begin
      e = exp_ar_q.pop_front();
      checks++;
      if (obs_ar_q.size() == 0) begin
        failures++; $display("FAIL split_ar missing exp addr=%h len=%0d", e.addr, e.len);
      end else begin
        o = obs_ar_q.pop_front();
        if (o !== e) begin
          failures++; $display("FAIL split_ar got addr=%h len=%0d exp addr=%h len=%0d", o.addr, o.len, e.addr, e.len);
        end
      end
    end
    checks++;
    if (obs_ar_q.size() != 0) begin failures++; $display("FAIL split_ar_extra got=%0d exp=0", obs_ar_q.size()); obs_ar_q.delete(); end
    while (exp_w_q.size() > 0) begin
      w = exp_w_q.pop_front();
      read_word(w.bank, w.addr, rd);
      checks++;
      if (rd !== w.data) begin failures++; $display("FAIL split_rd addr=%0d got=%h exp=%h", w.addr, rd, w.data); end
    end
  endtask

  task automatic test_backpressure();
    int b0, u0;
    bit ok;
    ar_t e, o;
    wexp_t w;
    logic [DW-1:0] rd;
    cfg_ardly = 5; cfg_gap = 40; cfg_early = 0;
    b0 = beat_total; u0 = ar_unstable;
    push_bursts(32'h0F80, 20);
    push_words(32'h0F80, 20, 1'b1);
    start_load(32'h0F80, 20, 1'b1);
    wait_done(2000, ok);
    checks++;
    if (!ok) begin failures++; $display("FAIL bp_done timeout"); end
    checks++;
    if (ar_unstable != u0) begin failures++; $display("FAIL bp_ar_stable got=%0d changes exp=0", ar_unstable - u0); end
    checks++;
    if (beat_total - b0 != 20) begin failures++; $display("FAIL bp_beats got=%0d exp=20", beat_total - b0); end
    while (exp_ar_q.size() > 0) begin
      e = exp_ar_q.pop_front();
      checks++;
      if (obs_ar_q.size() == 0) begin
        failures++; $display("FAIL bp_ar missing exp addr=%h len=%0d", e.addr, e.len);
      end else begin
        o = obs_ar_q.pop_front();
        if (o !== e) begin
          failures++; $display("FAIL bp_ar got addr=%h len=%0d exp addr=%h len=%0d", o.addr, o.len, e.addr, e.len);
        end
      end
    end
    obs_ar_q.delete();
    while (exp_w_q.size() > 0) begin
      w = exp_w_q.pop_front();
      read_word(w.bank, w.addr, rd);
      checks++;
      if (rd !== w.data) begin failures++; $display("FAIL bp_rd addr=%0d got=%h exp=%h", w.addr, rd, w.data); end
    end
  endtask

  task automatic test_len_zero();
    int a0;
    a0 = obs_ar_q.size();
    @(negedge clk);
    base_addr = 32'h8000; len = '0; wbank = 1'b0; ap_start = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if ({ap_done, arvalid} !== 2'b10) begin failures++; $display("FAIL len0_cycle1 done,arvalid got=%b exp=10", {ap_done, arvalid}); end
    @(posedge clk);
    #1;
    checks++;
    if ({ap_done, busy} !== 2'b00) begin failures++; $display("FAIL len0_cycle2 done,busy got=%b exp=00", {ap_done, busy}); end
    @(negedge clk) ap_start = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (obs_ar_q.size() != a0) begin failures++; $display("FAIL len0_axi got=%0d ARs exp=0", obs_ar_q.size() - a0); end
  endtask

  task automatic test_err_early();
    int b0;
    bit ok;
    cfg_ardly = 0; cfg_gap = 0; cfg_early = 3;
    b0 = beat_total;
    start_load(32'h7000, 8, 1'b0);
    wait_done(500, ok);
    cfg_early = 0;
    checks++;
    if (!ok) begin failures++; $display("FAIL err_done timeout"); end
    checks++;
    if (err !== 1'b1) begin failures++; $display("FAIL err_set got=%b exp=1", err); end
    checks++;
    if (beat_total - b0 != 8) begin failures++; $display("FAIL err_beats got=%0d exp=8", beat_total - b0); end
    obs_ar_q.delete();
    @(negedge clk);
    len = '0; ap_start = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if (err !== 1'b0) begin failures++; $display("FAIL err_clear got=%b exp=0", err); end
    @(negedge clk) ap_start = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_start_held();
    int d0, b0;
    bit ok;
    cfg_ardly = 0; cfg_gap = 0; cfg_early = 0;
    d0 = done_cnt; b0 = beat_total;
    @(negedge clk);
    base_addr = 32'h6000; len = (RW+1)'(8); wbank = 1'b1; ap_start = 1'b1;
    wait_done(500, ok);
    repeat (30) @(negedge clk);
    ap_start = 1'b0;
    checks++;
    if (!ok) begin failures++; $display("FAIL held_done timeout"); end
    checks++;
    if (done_cnt - d0 != 1) begin failures++; $display("FAIL held_pulses got=%0d exp=1", done_cnt - d0); end
    checks++;
    if (beat_total - b0 != 8 || obs_ar_q.size() != 1) begin
      failures++; $display("FAIL held_loads beats=%0d ars=%0d exp beats=8 ars=1", beat_total - b0, obs_ar_q.size());
    end
    obs_ar_q.delete();
  endtask

  task automatic test_reset_mid();
    bit ok;
    ar_t e, o;
    wexp_t w;
    logic [DW-1:0] rd;
    cfg_ardly = 0; cfg_gap = 40; cfg_early = 0;
    start_load(32'h4000, 32, 1'b0);
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (rready === 1'b1) begin ok = 1'b1; break; end
    end
    checks++;
    if (!ok) begin failures++; $display("FAIL rstmid_rready timeout"); end
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({rready, busy, arvalid} !== 3'b000) begin failures++; $display("FAIL rstmid_async rready,busy,arvalid got=%b exp=000", {rready, busy, arvalid}); end
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    exp_ar_q.delete(); obs_ar_q.delete(); exp_w_q.delete();
    cfg_gap = 0;
    repeat (2) @(negedge clk);
    e.addr = 32'h5000; e.len = 8'd7;
    exp_ar_q.push_back(e);
    push_words(32'h5000, 8, 1'b0);
    start_load(32'h5000, 8, 1'b0);
    wait_done(500, ok);
    checks++;
    if (!ok) begin failures++; $display("FAIL rstmid_done timeout"); end
    checks++;
    if (err !== 1'b0) begin failures++; $display("FAIL rstmid_err got=%b exp=0", err); end
    e = exp_ar_q.pop_front();
    checks++;
    if (obs_ar_q.size() != 1) begin
      failures++; $display("FAIL rstmid_ar count got=%0d exp=1", obs_ar_q.size());
    end else begin
      o = obs_ar_q.pop_front();
      if (o !== e) begin failures++; $display("FAIL rstmid_ar got addr=%h len=%0d exp addr=%h len=%0d", o.addr, o.len, e.addr, e.len); end
    end
    while (exp_w_q.size() > 0) begin
      w = exp_w_q.pop_front();
      read_word(w.bank, w.addr, rd);
      checks++;
      if (rd !== w.data) begin failures++; $display("FAIL rstmid_rd addr=%0d got=%h exp=%h", w.addr, rd, w.data); end
    end
  endtask

  initial begin
    checks = 0; failures = 0; done_cnt = 0; beat_total = 0; ar_unstable = 0;
    cfg_ardly = 0; cfg_gap = 0; cfg_early = 0;
    rst_n = 1'b0; ap_start = 1'b0; base_addr = '0; len = '0; wbank = 1'b0;
    rbank = 1'b0; braddr = '0;
    test_reset();
    test_single_burst();
    test_pingpong();
    test_split();
    test_backpressure();
    test_len_zero();
    test_err_early();
    test_start_held();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
